aes_256_key_expand: RTL and testbench

//  Iterative AES-256 key schedule that sits directly upstream of AES_256_roundop.

---
 rtl/aes_256_key_expand_pkg.sv | 63 ++++++
 rtl/aes_256_key_expand_sub_word.sv | 18 +
 rtl/aes_256_key_expand.sv | 118 +++++++++++
 tb/tb_aes_256_key_expand.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_256_key_expand_pkg.sv
// Shared definitions for the AES-256 key schedule.
//   - word/block/key widths and the number of stored round keys
//   - key-schedule state encoding
//   - GF(2^8) helpers: field multiply, forward S-box, round constant
package aes_256_key_expand_pkg;

    localparam int WORD_W     = 32;
    localparam int BLOCK_W    = 128;
    localparam int CIPHER_W   = 256;
    localparam int NUM_RK_DEF = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXP  = 2'd1,
        DONE = 2'd2
    } ks_state_t;

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] aa;
        acc = 8'h00;
        aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Forward S-box: multiplicative inverse as x^254 (0 maps to 0),
    // followed by the affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] inv;
        p   = x;
        inv = 8'h01;
        // 254 = 2+4+8+16+32+64+128: square repeatedly and multiply each in.
        for (int i = 1; i < 8; i++) begin
            p   = gf_mul(p, p);
            inv = gf_mul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    // Round constant for indices 1..7 (AES-256 needs no more).
    function automatic logic [7:0] aes_rcon(input logic [2:0] idx);
        logic [7:0] rc;
        case (idx)
            3'd1:    rc = 8'h01;
            3'd2:    rc = 8'h02;
            3'd3:    rc = 8'h04;
            3'd4:    rc = 8'h08;
            3'd5:    rc = 8'h10;
            3'd6:    rc = 8'h20;
            3'd7:    rc = 8'h40;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_256_key_expand_sub_word.sv
// SubWord: forward S-box applied independently to each byte of a 32-bit word.
// Ports:
//   word_in   in  32  word to substitute
//   word_out  out 32  substituted word
module aes_256_key_expand_sub_word
    import aes_256_key_expand_pkg::*;
(
    input  logic [WORD_W-1:0] word_in,
    output logic [WORD_W-1:0] word_out
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_byte
            assign word_out[gi*8 +: 8] = aes_sbox(word_in[gi*8 +: 8]);
        end
    endgenerate

endmodule

// File: rtl/aes_256_key_expand.sv
// Iterative AES-256 key schedule. A 256-bit cipher key is accepted in one
// cycle (RK0/RK1), then RK2..RK14 are produced one per cycle and stored.
// Any stored forward round key can be read through rk_idx/rk_data.
// Ports:
//   clk        in   1    clock
//   rst_n      in   1    asynchronous active-low reset
//   key_in     in   256  cipher key, [255:224] = w0
//   key_valid  in   1    key_in valid
//   key_ready  out  1    key accepted when key_valid is also high
//   busy       out  1    expansion in progress
//   keys_vld   out  1    all round keys valid and stable
//   rk_idx     in   4    round key index 0..14 (others read as zero)
//   rk_data    out  128  selected round key, [127:96] = column 0
module aes_256_key_expand
    import aes_256_key_expand_pkg::*;
#(
    parameter int KEY_W  = CIPHER_W,
    parameter int BLK_W  = BLOCK_W,
    parameter int NUM_RK = NUM_RK_DEF,
    parameter bit RD_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              busy,
    output logic              keys_vld,
    input  logic [3:0]        rk_idx,
    output logic [BLK_W-1:0]  rk_data
);

    ks_state_t         state_reg;
    logic [3:0]        r_reg;
    logic [BLK_W-1:0]  prev1_reg;
    logic [BLK_W-1:0]  prev2_reg;
    logic [BLK_W-1:0]  rk_mem [0:NUM_RK-1];

    logic              accept;
    logic              r_even;
    logic [31:0]       last_w;
    logic [31:0]       sub_in;
    logic [31:0]       sub_out;
    logic [31:0]       t_word;
    logic [31:0]       n0, n1, n2, n3;
    logic [BLK_W-1:0]  rk_next;
    logic [BLK_W-1:0]  rk_rd;

    assign key_ready = (state_reg != EXP);
    assign busy      = (state_reg == EXP);
    assign keys_vld  = (state_reg == DONE);
    assign accept    = key_valid && key_ready;

    // Even r starts a new 8-word group (RotWord + Rcon); odd r is the
    // mid-group SubWord-only step of the 256-bit schedule.
    assign r_even = ~r_reg[0];
    assign last_w = prev1_reg[31:0];
    assign sub_in = r_even ? {last_w[23:0], last_w[31:24]} : last_w;

    aes_256_key_expand_sub_word u_sub_word (
        .word_in  (sub_in),
        .word_out (sub_out)
    );

    assign t_word  = sub_out ^ (r_even ? {aes_rcon(r_reg[3:1]), 24'h000000} : 32'h0);
    assign n0      = prev2_reg[127:96] ^ t_word;
    assign n1      = prev2_reg[95:64]  ^ n0;
    assign n2      = prev2_reg[63:32]  ^ n1;
    assign n3      = prev2_reg[31:0]   ^ n2;
    assign rk_next = {n0, n1, n2, n3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            r_reg     <= 4'd0;
            prev1_reg <= '0;
            prev2_reg <= '0;
            for (int i = 0; i < NUM_RK; i++) begin
                rk_mem[i] <= '0;
            end
        end else if (accept) begin
            rk_mem[0] <= key_in[KEY_W-1 -: BLK_W];
            rk_mem[1] <= key_in[BLK_W-1:0];
            prev2_reg <= key_in[KEY_W-1 -: BLK_W];
            prev1_reg <= key_in[BLK_W-1:0];
            r_reg     <= 4'd2;
            state_reg <= EXP;
        end else if (state_reg == EXP) begin
            rk_mem[r_reg] <= rk_next;
            prev2_reg     <= prev1_reg;
            prev1_reg     <= rk_next;
            r_reg         <= r_reg + 4'd1;
            if (r_reg == 4'(NUM_RK - 1)) begin
                state_reg <= DONE;
            end
        end
    end

    // Read port; reads during expansion see whatever is stored so far.
    assign rk_rd = (rk_idx < 4'(NUM_RK)) ? rk_mem[rk_idx] : '0;

    generate
        if (RD_REG) begin : g_rd_reg
            logic [BLK_W-1:0] rk_data_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rk_data_reg <= '0;
                end else begin
                    rk_data_reg <= rk_rd;
                end
            end
            assign rk_data = rk_data_reg;
        end else begin : g_rd_comb
            assign rk_data = rk_rd;
        end
    endgenerate

endmodule

// File: tb/tb_aes_256_key_expand.sv
// Bench for the AES-256 key schedule: FIPS-197 vectors, random keys against
// a word-level FIPS key-expansion model, handshake, reset and read-port checks.
module tb_aes_256_key_expand;

    logic         clk;
    logic         rst_n;
    logic [255:0] key_in;
    logic         key_valid;
    logic [3:0]   rk_idx;
    logic         key_ready, busy, keys_vld;
    logic [127:0] rk_data;
    logic         key_ready_r, busy_r, keys_vld_r;
    logic [127:0] rk_data_r;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [15];

    aes_256_key_expand #(.RD_REG(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready), .busy(busy), .keys_vld(keys_vld),
        .rk_idx(rk_idx), .rk_data(rk_data)
    );

    aes_256_key_expand #(.RD_REG(1'b1)) dut_r (
        .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_valid(key_valid),
        .key_ready(key_ready_r), .busy(busy_r), .keys_vld(keys_vld_r),
        .rk_idx(rk_idx), .rk_data(rk_data_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return (a[7]) ? ((a << 1) ^ 8'h1b) : (a << 1);
    endfunction

    function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 0) begin
            if (bb[0]) res ^= aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return res;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] c;
        logic [7:0] s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Standard FIPS-197 word expansion with Nk=8, Nr=14.
    task automatic model_expand(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            temp = w[i-1];
            if (i % 8 == 0) begin
                temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (i % 8 == 4) begin
                temp = sub_word(temp);
            end
            w[i] = w[i-8] ^ temp;
        end
        for (int j = 0; j < 15; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [255:0] k);
        key_in    = k;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    // Called in cycle 1 after acceptance; ends in cycle 14.
    task automatic check_timing(input string tag);
        for (int c = 1; c < 14; c++) begin
            check($sformatf("%s keys_vld c%0d", tag, c), 128'(keys_vld), 128'(0));
            check($sformatf("%s key_ready c%0d", tag, c), 128'(key_ready), 128'(0));
            step();
        end
        check({tag, " keys_vld c14"}, 128'(keys_vld), 128'(1));
        check({tag, " busy c14"}, 128'(busy), 128'(0));
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rk_idx = 4'(i);
            #1;
            check($sformatf("%s rk%0d", tag, i), rk_data, (i < 15) ? exp_rk[i] : 128'h0);
        end
    endtask

    task automatic wait_keys_vld(input string tag);
        int n;
        n = 0;
        while (!keys_vld && n < 40) begin
            step();
            n++;
        end
        check({tag, " keys_vld timeout"}, 128'(keys_vld), 128'(1));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [255:0] k;
        logic [255:0] k2;
        logic [3:0]   prev_idx;
        int           acc;

        build_sbox();
        rst_n = 1'b0; key_in = '0; key_valid = 1'b0; rk_idx = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset key_ready", 128'(key_ready), 128'(1));
        check("reset busy", 128'(busy), 128'(0));
        check("reset keys_vld", 128'(keys_vld), 128'(0));
        check("reset rk_data", rk_data, 128'h0);
        check("reset rk_data_r", rk_data_r, 128'h0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // FIPS-197 A.3
        k = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        load_key(k);
        check("a3 busy c1", 128'(busy), 128'(1));
        check_timing("a3");
        model_expand(k);
        read_all("a3");
        rk_idx = 4'd2; #1;
        check("a3 fips rk2", rk_data, 128'h9ba354118e6925afa51a8b5f2067fcde);
        rk_idx = 4'd14; #1;
        check("a3 fips rk14", rk_data, 128'hfe4890d1e6188d0b046df344706c631e);

        // FIPS-197 C.3, re-keyed from DONE
        step();
        k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        load_key(k);
        check_timing("c3");
        model_expand(k);
        read_all("c3");
        rk_idx = 4'd0; #1;
        check("c3 fips rk0", rk_data, 128'h000102030405060708090a0b0c0d0e0f);
        rk_idx = 4'd1; #1;
        check("c3 fips rk1", rk_data, 128'h101112131415161718191a1b1c1d1e1f);
        rk_idx = 4'd14; #1;
        check("c3 fips rk14", rk_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);

        // key_valid held for 20 cycles from IDLE
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        step();
        acc = 0;
        k2  = '0;
        for (int c = 0; c < 20; c++) begin
            key_in    = rand_key();
            key_valid = 1'b1;
            #1;
            check($sformatf("hold key_ready c%0d", c), 128'(key_ready),
                  128'((c == 0) || (c == 14)));
            if (key_ready) acc++;
            if (c == 14) k2 = key_in;
            step();
        end
        key_valid = 1'b0;
        check("hold acceptances", 128'(acc), 128'(2));
        wait_keys_vld("hold");
        model_expand(k2);
        read_all("hold");

        // asynchronous reset mid-expansion
        step();
        load_key(rand_key());
        repeat (6) step();
        #2 rst_n = 1'b0;
        #1;
        rk_idx = 4'd0; #1;
        check("areset key_ready", 128'(key_ready), 128'(1));
        check("areset busy", 128'(busy), 128'(0));
        check("areset keys_vld", 128'(keys_vld), 128'(0));
        check("areset rk_data", rk_data, 128'h0);
        check("areset rk_data_r", rk_data_r, 128'h0);
        @(negedge clk) rst_n = 1'b1;
        step();
        k = rand_key();
        load_key(k);
        check_timing("post_reset");
        model_expand(k);
        read_all("post_reset");

        // out-of-range index and registered read latency
        @(negedge clk) rk_idx = 4'd15;
        #1;
        check("idx15 rk_data", rk_data, 128'h0);
        step();
        prev_idx = rk_idx;
        for (int n = 0; n < 20; n++) begin
            rk_idx = 4'($urandom_range(0, 15));
            check($sformatf("rdreg idx%0d", prev_idx), rk_data_r,
                  (prev_idx < 15) ? exp_rk[prev_idx] : 128'h0);
            prev_idx = rk_idx;
            step();
        end

        // re-key from DONE with the all-zero key
        load_key(256'h0);
        check_timing("zero");
        model_expand(256'h0);
        read_all("zero");

        // random keys
        for (int n = 0; n < 3; n++) begin
            step();
            k = rand_key();
            load_key(k);
            check_timing($sformatf("rand%0d", n));
            model_expand(k);
            read_all($sformatf("rand%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
